// File: rtl/targ_predictor_pkg.sv
// Shared predictor types: lookup/feedback interface structs and the table entry layout.
package targ_predictor_pkg;

  localparam int unsigned addr_width           = 32;
  localparam int unsigned targ_pred_cnt        = 2;
  localparam int unsigned targ_pred_conf_width = 2;

  typedef struct packed {
    logic [addr_width-1:0] base_pc;
    logic                  valid;
  } targ_pred_req_t;

  typedef struct packed {
    logic [targ_pred_cnt-1:0]                 valid;
    logic [targ_pred_cnt-1:0][addr_width-1:0] pred_pc;
  } targ_pred_rsp_t;

  typedef struct packed {
    logic [addr_width-1:0] base_pc;
    logic [addr_width-1:0] targ_pc;
    logic                  valid;
  } targ_pred_fb_t;

  typedef struct packed {
    logic                            svalid;
    logic [addr_width-1:0]           targ_pc;
    logic [targ_pred_conf_width-1:0] conf;
  } targ_pred_slot_t;

  // Tag is stored zero-extended to addr_width so the entry layout is independent of table depth.
  typedef struct packed {
    logic                                  evalid;
    logic [addr_width-1:0]                 tag;
    targ_pred_slot_t [targ_pred_cnt-1:0]   slot;
  } targ_pred_entry_t;

  typedef enum logic {
    INIT,
    READY
  } targ_pred_state_t;

  function automatic logic [addr_width-1:0] pc_tag(input logic [addr_width-1:0] pc,
                                                   input int unsigned idx_width);
    return pc >> (2 + idx_width);
  endfunction

endpackage

// File: rtl/targ_pred_update.sv
// Combinational read-modify-write of one predictor entry from a resolved JALR.
module targ_pred_update
  import targ_predictor_pkg::*;
#(
  parameter int unsigned targ_cnt   = targ_pred_cnt,
  parameter int unsigned conf_width = targ_pred_conf_width,
  parameter int unsigned idx_width  = 4
) (
  input  targ_pred_entry_t      old_entry,
  input  logic [addr_width-1:0] fb_base_pc,
  input  logic [addr_width-1:0] fb_targ_pc,
  output targ_pred_entry_t      new_entry
);

  localparam int unsigned sel_width = (targ_cnt > 1) ? $clog2(targ_cnt) : 1;
  localparam logic [conf_width-1:0] conf_max  = '1;
  localparam logic [conf_width-1:0] conf_one  = conf_width'(1);
  localparam logic [sel_width-1:0]  last_slot = sel_width'(targ_cnt - 1);

  logic                 tag_hit;
  logic                 match_found;
  logic                 free_found;
  logic [sel_width-1:0] match_sel;
  logic [sel_width-1:0] free_sel;
  logic [addr_width-1:0] fb_tag;
  targ_pred_slot_t      swap_tmp;

  always_comb begin
    fb_tag      = pc_tag(fb_base_pc, idx_width);
    tag_hit     = old_entry.evalid && (old_entry.tag == fb_tag);
    match_found = 1'b0;
    match_sel   = '0;
    free_found  = 1'b0;
    free_sel    = '0;
    for (int unsigned k = 0; k < targ_cnt; k++) begin
      if (!match_found && old_entry.slot[k].svalid &&
          (old_entry.slot[k].targ_pc == fb_targ_pc)) begin
        match_found = 1'b1;
        match_sel   = sel_width'(k);
      end
      if (!free_found && !old_entry.slot[k].svalid) begin
        free_found = 1'b1;
        free_sel   = sel_width'(k);
      end
    end
  end

  always_comb begin
    new_entry = old_entry;
    swap_tmp  = '0;
    if (!tag_hit) begin
      new_entry         = '0;
      new_entry.evalid  = 1'b1;
      new_entry.tag     = fb_tag;
      new_entry.slot[0] = '{svalid: 1'b1, targ_pc: fb_targ_pc, conf: conf_one};
    end else if (match_found) begin
      if (new_entry.slot[match_sel].conf != conf_max)
        new_entry.slot[match_sel].conf = new_entry.slot[match_sel].conf + 1'b1;
      // Promotion moves a slot up by at most one position per update.
      if ((match_sel != '0) &&
          (new_entry.slot[match_sel].conf > new_entry.slot[match_sel - 1'b1].conf)) begin
        swap_tmp                           = new_entry.slot[match_sel];
        new_entry.slot[match_sel]          = new_entry.slot[match_sel - 1'b1];
        new_entry.slot[match_sel - 1'b1]   = swap_tmp;
      end
    end else if (free_found) begin
      new_entry.slot[free_sel] = '{svalid: 1'b1, targ_pc: fb_targ_pc, conf: conf_one};
    end else begin
      for (int unsigned k = 0; k < targ_cnt; k++) begin
        if (new_entry.slot[k].conf != '0)
          new_entry.slot[k].conf = new_entry.slot[k].conf - 1'b1;
      end
      if (new_entry.slot[last_slot].conf == '0)
        new_entry.slot[last_slot] = '{svalid: 1'b1, targ_pc: fb_targ_pc, conf: conf_one};
    end
  end

endmodule

// File: rtl/targ_predictor.sv
// Multi-target indirect-jump predictor: direct-mapped table, per-s-pipe combinational
// lookup, two-stage feedback pipeline feeding a confidence-ordered slot update.
module targ_predictor
  import targ_predictor_pkg::*;
#(
  parameter int unsigned s_pipe_cnt = 3,
  parameter int unsigned entry_cnt  = 16,
  parameter int unsigned targ_cnt   = targ_pred_cnt,
  parameter int unsigned conf_width = targ_pred_conf_width
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  targ_pred_req_t [s_pipe_cnt-1:0]  targ_pred_req,
  output targ_pred_rsp_t [s_pipe_cnt-1:0]  targ_pred_rsp,
  input  targ_pred_fb_t                    targ_pred_fb,
  output logic                             busy
);

  localparam int unsigned idx_width = $clog2(entry_cnt);
  localparam logic [idx_width-1:0] last_idx = idx_width'(entry_cnt - 1);

  targ_pred_entry_t       table_q [entry_cnt];
  targ_pred_state_t       state_q;
  targ_pred_state_t       state_d;
  logic [idx_width-1:0]   sweep_q;
  targ_pred_fb_t          fb_q;
  logic [idx_width-1:0]   fb_idx;
  targ_pred_entry_t       upd_entry;

  function automatic targ_pred_rsp_t lookup(input targ_pred_req_t   req,
                                            input targ_pred_entry_t e,
                                            input logic             ready);
    targ_pred_rsp_t r;
    r = '0;
    if (ready && req.valid && e.evalid && (e.tag == pc_tag(req.base_pc, idx_width))) begin
      for (int unsigned k = 0; k < targ_cnt; k++) begin
        r.valid[k]   = e.slot[k].svalid;
        r.pred_pc[k] = e.slot[k].targ_pc;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_q == last_idx) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    busy = (state_q == INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sweep_q <= '0;
    else if (state_q == INIT) sweep_q <= sweep_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q <= '0;
    end else if (en) begin
      fb_q <= targ_pred_fb;
      if (state_q != READY) fb_q.valid <= 1'b0;
    end
  end

  assign fb_idx = fb_q.base_pc[2 +: idx_width];

  targ_pred_update #(
    .targ_cnt   (targ_cnt),
    .conf_width (conf_width),
    .idx_width  (idx_width)
  ) u_update (
    .old_entry  (table_q[fb_idx]),
    .fb_base_pc (fb_q.base_pc),
    .fb_targ_pc (fb_q.targ_pc),
    .new_entry  (upd_entry)
  );

  // Table has no reset; the INIT sweep invalidates entries one per cycle instead.
  always_ff @(posedge clk) begin
    if (state_q == INIT)
      table_q[sweep_q].evalid <= 1'b0;
    else if (en && fb_q.valid)
      table_q[fb_idx] <= upd_entry;
  end

  always_comb begin
    for (int unsigned p = 0; p < s_pipe_cnt; p++) begin
      targ_pred_rsp[p] = lookup(targ_pred_req[p],
                                table_q[targ_pred_req[p].base_pc[2 +: idx_width]],
                                state_q == READY);
    end
  end

endmodule
